// File: rtl/atpg_pattern_sequencer_pkg.sv
// atpg_seq_pkg: shared states, pattern-entry layout and default timing for the ATPG sequencer.
// The xm field exists only when ATPG_XMASK_EN is defined.
package atpg_seq_pkg;
   localparam int STIM_W     = 4;
   localparam int HOLD_CYC_D = 8;
   localparam int CAPT_CYC_D = 1;
   typedef enum logic [2:0] {IDLE, INIT, LAUNCH, REPORT, DONE} state_t;
   typedef struct packed {
      logic [STIM_W-1:0] v1;
      logic [STIM_W-1:0] v2;
      logic              exp;
`ifdef ATPG_XMASK_EN
      logic              xm;
`endif
   } pat_t;
endpackage

// File: rtl/atpg_pattern_sequencer_if.sv
// atpg_pattern_sequencer_if: per-pattern result stream from the sequencer to a logger.
interface atpg_pattern_sequencer_if #(parameter int PAT_AW = 2);
   logic              res_valid;
   logic              res_ready;
   logic [PAT_AW-1:0] res_idx;
   logic              res_y;
   logic              res_pass;
   modport master (output res_valid, res_idx, res_y, res_pass, input res_ready);
   modport slave  (input res_valid, res_idx, res_y, res_pass, output res_ready);
endinterface

// File: rtl/atpg_pattern_sequencer_ram.sv
// atpg_pattern_ram: pattern register file, one write port and one registered read port.
// Read is write-first so a pattern written in the start cycle is seen by the run.
module atpg_pattern_ram
   import atpg_seq_pkg::*;
#(
   parameter int NUM_PAT = 4,
   parameter int PAT_AW  = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PAT_AW-1:0] waddr,
   input  pat_t              wdata,
   input  logic [PAT_AW-1:0] raddr,
   output pat_t              rdata
);
   pat_t mem [NUM_PAT];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/atpg_pattern_sequencer.sv
// atpg_pattern_sequencer: applies init/launch pattern pairs, captures y and streams pass/fail results.
// Define ATPG_XMASK_EN to add a per-pattern x-mask (pat_xm) that forces a pass.
module atpg_pattern_sequencer
   import atpg_seq_pkg::*;
#(
   parameter int NUM_IN   = STIM_W,
   parameter int NUM_PAT  = 4,
   parameter int PAT_AW   = 2,
   parameter int HOLD_CYC = HOLD_CYC_D,
   parameter int CAPT_CYC = CAPT_CYC_D
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pat_we,
   input  logic [PAT_AW-1:0]   pat_addr,
   input  logic [NUM_IN-1:0]   pat_v1,
   input  logic [NUM_IN-1:0]   pat_v2,
   input  logic                pat_exp,
`ifdef ATPG_XMASK_EN
   input  logic                pat_xm,
`endif
   input  logic                start,
   output logic [NUM_IN-1:0]   stim,
   input  logic                dut_y,
   output logic                busy,
   output logic                done,
   output logic [PAT_AW:0]     fail_cnt,
   atpg_pattern_sequencer_if.master res
);
   localparam int CW = $clog2(HOLD_CYC + 1);
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [PAT_AW-1:0] idx, idx_n;
   logic [PAT_AW:0]   fail_n;
   logic              y_q, pass_q, capture, hit, we;
   pat_t              wr, rd;
   always_comb begin
      wr.v1  = pat_v1;
      wr.v2  = pat_v2;
      wr.exp = pat_exp;
`ifdef ATPG_XMASK_EN
      wr.xm  = pat_xm;
`endif
   end
   assign we = pat_we && !busy && (int'(pat_addr) < NUM_PAT);
   // Read address follows the next index so the entry is ready when INIT begins.
   atpg_pattern_ram #(.NUM_PAT(NUM_PAT), .PAT_AW(PAT_AW)) u_ram (
      .clk(clk), .we(we), .waddr(pat_addr), .wdata(wr), .raddr(idx_n), .rdata(rd)
   );
   assign busy    = state inside {INIT, LAUNCH, REPORT};
   assign done    = state == DONE;
   assign stim    = state == INIT ? rd.v1 : (state == LAUNCH || state == REPORT) ? rd.v2 : '0;
   assign capture = state == LAUNCH && cnt == CW'(CAPT_CYC);
`ifdef ATPG_XMASK_EN
   assign hit = (dut_y == rd.exp) || rd.xm;
`else
   assign hit = dut_y == rd.exp;
`endif
   assign res.res_valid = state == REPORT;
   assign res.res_idx   = idx;
   assign res.res_y     = y_q;
   assign res.res_pass  = pass_q;
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      fail_n  = fail_cnt;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start) begin
               state_n = INIT;
               idx_n   = '0;
               fail_n  = '0;
            end
         end
         INIT, LAUNCH: begin
            if (cnt == CW'(HOLD_CYC - 1)) begin
               state_n = state == INIT ? LAUNCH : REPORT;
               cnt_n   = '0;
            end
         end
         REPORT: begin
            cnt_n = '0;
            if (res.res_ready) begin
               fail_n  = (!pass_q && fail_cnt != '1) ? fail_cnt + 1'b1 : fail_cnt;
               state_n = idx == PAT_AW'(NUM_PAT - 1) ? DONE : INIT;
               idx_n   = idx == PAT_AW'(NUM_PAT - 1) ? idx : idx + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         fail_cnt <= '0;
         y_q      <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         fail_cnt <= fail_n;
         if (capture) begin
            y_q    <= dut_y;
            pass_q <= hit;
         end
      end
   end
endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// tb_atpg_pattern_sequencer: table-driven, scoreboard-checked bench for the ATPG sequencer.
// Build with ATPG_XMASK_EN to also exercise the x-mask run.
module tb_atpg_pattern_sequencer;
   import atpg_seq_pkg::*;
   typedef struct {
      logic [3:0] v1, v2;
      logic       exp, g_y, g_pass, s_pass;
   } vec_t;
   typedef struct {
      logic [1:0] idx;
      logic       y, pass;
      logic [3:0] v2;
   } sb_t;
   logic       clk, rst, pat_we, pat_exp, start, dut_y, busy, done, stuck;
   logic [1:0] pat_addr;
   logic [3:0] pat_v1, pat_v2, stim;
   logic [2:0] fail_cnt;
`ifdef ATPG_XMASK_EN
   logic       pat_xm;
`endif
   vec_t tbl [4];
   sb_t  sb [$];
   int   n_chk = 0, n_fail = 0, done_cnt = 0;
   atpg_pattern_sequencer_if #(.PAT_AW(2)) res_bus ();
   atpg_pattern_sequencer dut (
      .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_v1(pat_v1),
      .pat_v2(pat_v2), .pat_exp(pat_exp),
`ifdef ATPG_XMASK_EN
      .pat_xm(pat_xm),
`endif
      .start(start), .stim(stim), .dut_y(dut_y), .busy(busy), .done(done),
      .fail_cnt(fail_cnt), .res(res_bus)
   );
   // Stand-in for injection_module: golden y, or stuck-at-0.
   assign dut_y = stuck ? 1'b0 : (stim == 4'b0110 || stim == 4'b0001);
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && done) done_cnt++;
      if (!rst && res_bus.res_valid && res_bus.res_ready) begin
         if (sb.size() == 0) chk("sb_unexpected_result", 32'(res_bus.res_idx), 32'hFF);
         else begin
            sb_t e;
            e = sb.pop_front();
            chk("res_idx", 32'(res_bus.res_idx), 32'(e.idx));
            chk("res_y", 32'(res_bus.res_y), 32'(e.y));
            chk("res_pass", 32'(res_bus.res_pass), 32'(e.pass));
            chk("report_stim", 32'(stim), 32'(e.v2));
         end
      end
   end
   task automatic write_pat(input int i, input logic xm);
      pat_we = 1'b1; pat_addr = 2'(i);
      pat_v1 = tbl[i].v1; pat_v2 = tbl[i].v2; pat_exp = tbl[i].exp;
`ifdef ATPG_XMASK_EN
      pat_xm = xm;
`endif
      @(posedge clk); #1;
      pat_we = 1'b0;
   endtask
   task automatic run(input bit sa, input bit xm0, input int stall_idx, input int abort_at,
                      input int poke_at, output int n);
      int   stalled;
      logic held_y;
      stuck = sa; stalled = 0; held_y = 1'b0;
      for (int i = 0; i < 4; i++)
         sb.push_back('{idx: 2'(i), y: sa ? 1'b0 : tbl[i].g_y,
                        pass: (xm0 && i == 0) ? 1'b1 : sa ? tbl[i].s_pass : tbl[i].g_pass,
                        v2: tbl[i].v2});
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; n = 1;
      while (!done && n < 400) begin
         if (n == abort_at) begin
            chk("pre_abort_fail_cnt", 32'(fail_cnt), 32'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_stim", 32'(stim), 32'd0);
            chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            sb.delete();
            return;
         end
         if (n == poke_at) begin
            pat_we = 1'b1; pat_addr = 2'd0; pat_v1 = 4'hF; pat_v2 = 4'hF; pat_exp = 1'b0;
            start = 1'b1;
         end else begin
            pat_we = 1'b0; start = 1'b0;
         end
         if (res_bus.res_valid && int'(res_bus.res_idx) == stall_idx && stalled < 20) begin
            if (stalled == 0) held_y = res_bus.res_y;
            else begin
               chk("stall_idx", 32'(res_bus.res_idx), 32'(stall_idx));
               chk("stall_y", 32'(res_bus.res_y), 32'(held_y));
               chk("stall_stim", 32'(stim), 32'(tbl[stall_idx].v2));
            end
            res_bus.res_ready = 1'b0;
            stalled++;
         end else res_bus.res_ready = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      pat_we = 1'b0; start = 1'b0; res_bus.res_ready = 1'b1;
      chk("run_timeout", 32'(done), 32'd1);
   endtask
   task automatic end_run(input string tag, input int n, input int exp_n, input int exp_fail, input int d0);
      chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(exp_fail));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask
   initial begin
      int n, d0;
      tbl[0] = '{4'b0001, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{4'b0110, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0};
      rst = 1'b1; pat_we = 1'b0; pat_addr = '0; pat_v1 = '0; pat_v2 = '0; pat_exp = 1'b0;
      start = 1'b0; stuck = 1'b0; res_bus.res_ready = 1'b1;
`ifdef ATPG_XMASK_EN
      pat_xm = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_stim", 32'(stim), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(res_bus.res_valid), 32'd0);
      chk("rst_idx", 32'(res_bus.res_idx), 32'd0);
      chk("rst_y", 32'(res_bus.res_y), 32'd0);
      chk("rst_pass", 32'(res_bus.res_pass), 32'd0);
      chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
      for (int i = 0; i < 4; i++) write_pat(i, 1'b0);
      d0 = done_cnt; run(1'b0, 1'b0, -1, -1, -1, n); end_run("golden", n, 69, 0, d0);
      d0 = done_cnt; run(1'b1, 1'b0, -1, -1, -1, n); end_run("sa0", n, 69, 2, d0);
      d0 = done_cnt; run(1'b0, 1'b0, 1, -1, -1, n); end_run("stall", n, 89, 0, d0);
      d0 = done_cnt; run(1'b1, 1'b0, -1, 45, -1, n);
      repeat (3) @(posedge clk); #1;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
      d0 = done_cnt; run(1'b0, 1'b0, -1, -1, 5, n); end_run("poke", n, 69, 0, d0);
      d0 = done_cnt; run(1'b0, 1'b0, -1, -1, -1, n); end_run("after_poke", n, 69, 0, d0);
`ifdef ATPG_XMASK_EN
      write_pat(0, 1'b1);
      d0 = done_cnt; run(1'b1, 1'b1, -1, -1, -1, n); end_run("xmask", n, 69, 1, d0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
